fpu_wb_queue: RTL

FPU_WB_QUEUE -- requirements
Module: fpu_wb_queue

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fpu_wb_queue.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP writeback queue: entry layout, flag bit indices
// and the default queue depth.
package fpu_pkg;

   localparam int FPU_DEPTH_DEFAULT = 4;

   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   // Result data is width-parameterised, so the queue keeps it in a parallel array.
   typedef struct packed {
      logic       alloc;
      logic       filled;
      logic [4:0] rd;
      logic       is_int;
      logic [4:0] flags;
   } fpu_wb_entry_t;

endpackage : fpu_pkg

// File: rtl/fpu_wb_queue.sv
// In-order writeback queue between FP issue, the FP execute unit and the register files.
// Optional accrued exception flags are built when FPU_WB_FFLAGS_EN is defined.
module fpu_wb_queue
   import fpu_pkg::*;
#(
   parameter int FPLEN = 32,
   parameter int DEPTH = FPU_DEPTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   issue_valid,
   input  logic [4:0]             issue_rd,
   input  logic                   issue_is_int,
   output logic                   issue_ready,
   input  logic                   fpu_complete,
   input  logic [FPLEN-1:0]       fpu_result_1,
   input  logic [31:0]            fpu_result_rd,
   input  logic [4:0]             fpu_flags,
   output logic                   wb_valid,
   input  logic                   wb_ready,
   output logic                   wb_is_int,
   output logic [4:0]             wb_rd,
   output logic [FPLEN-1:0]       wb_data,
   output logic [4:0]             wb_flags,
   input  logic                   flush,
   input  logic                   fflags_clr,
   output logic [4:0]             fflags,
   output logic                   orphan_err,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fpu_wb_entry_t    entry_r [DEPTH];
   logic [FPLEN-1:0] data_r  [DEPTH];
   logic [PW-1:0]    head_r;
   logic [PW-1:0]    tail_r;
   logic [PW-1:0]    fill_r;
   logic [CW-1:0]    count_r;
   logic             ready_en_r;
   logic             orphan_r;

   logic             issue_ready_s;
   logic             push_s;
   logic             pop_s;
   logic             fill_ok_s;
   logic             cmpl_s;
   logic             orphan_s;
   logic             wb_valid_s;
   logic             wb_is_int_s;
   logic [4:0]       wb_rd_s;
   logic [FPLEN-1:0] wb_data_s;
   logic [4:0]       wb_flags_s;

   // Handshake decode; a completion only lands on an entry allocated in an earlier cycle.
   always_comb begin
      issue_ready_s = ready_en_r & (count_r < CW'(DEPTH));
      push_s        = issue_valid & issue_ready_s;
      wb_valid_s    = entry_r[head_r].alloc & entry_r[head_r].filled;
      pop_s         = wb_valid_s & wb_ready;
      fill_ok_s     = entry_r[fill_r].alloc & ~entry_r[fill_r].filled;
      cmpl_s        = fpu_complete & fill_ok_s;
      orphan_s      = fpu_complete & ~fill_ok_s;
   end

   // Writeback payload reads as zero whenever nothing is presented.
   always_comb begin
      if (wb_valid_s) begin
         wb_is_int_s = entry_r[head_r].is_int;
         wb_rd_s     = entry_r[head_r].rd;
         wb_data_s   = data_r[head_r];
         wb_flags_s  = entry_r[head_r].flags;
      end else begin
         wb_is_int_s = 1'b0;
         wb_rd_s     = 5'd0;
         wb_data_s   = '0;
         wb_flags_s  = 5'd0;
      end
   end

   // Entry storage, the three ring pointers and occupancy count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_r[i] <= '0;
            data_r[i]  <= '0;
         end
         head_r  <= '0;
         tail_r  <= '0;
         fill_r  <= '0;
         count_r <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_r[i] <= '0;
         end
         head_r  <= '0;
         tail_r  <= '0;
         fill_r  <= '0;
         count_r <= '0;
      end else begin
         if (push_s) begin
            entry_r[tail_r] <= '{alloc: 1'b1, filled: 1'b0, rd: issue_rd,
                                 is_int: issue_is_int, flags: 5'd0};
            tail_r <= tail_r + PW'(1);
         end
         if (cmpl_s) begin
            entry_r[fill_r].filled <= 1'b1;
            entry_r[fill_r].flags  <= fpu_flags;
            data_r[fill_r]         <= entry_r[fill_r].is_int ? FPLEN'(fpu_result_rd)
                                                             : fpu_result_1;
            fill_r <= fill_r + PW'(1);
         end
         if (pop_s) begin
            entry_r[head_r] <= '0;
            head_r <= head_r + PW'(1);
         end
         count_r <= count_r + CW'(push_s) - CW'(pop_s);
      end
   end

   // Issue stays blocked until the first edge after reset is released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_en_r <= 1'b0;
      end else begin
         ready_en_r <= 1'b1;
      end
   end

   // Sticky record of completions that had no entry to land in; flush does not clear it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         orphan_r <= 1'b0;
      end else begin
         orphan_r <= orphan_r | (orphan_s & ~flush);
      end
   end

`ifdef FPU_WB_FFLAGS_EN
   logic [4:0] fflags_r;

   // Accrue exception flags of every retired result; a clear keeps only this cycle's flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fflags_r <= 5'd0;
      end else if (fflags_clr) begin
         fflags_r <= (pop_s & ~flush) ? wb_flags_s : 5'd0;
      end else if (pop_s & ~flush) begin
         fflags_r <= fflags_r | wb_flags_s;
      end
   end

   assign fflags = fflags_r;
`else
   logic unused_fflags_clr_s;
   assign unused_fflags_clr_s = fflags_clr;
   assign fflags = 5'd0;
`endif

   assign issue_ready = issue_ready_s;
   assign wb_valid    = wb_valid_s;
   assign wb_is_int   = wb_is_int_s;
   assign wb_rd       = wb_rd_s;
   assign wb_data     = wb_data_s;
   assign wb_flags    = wb_flags_s;
   assign orphan_err  = orphan_r;
   assign count       = count_r;

endmodule : fpu_wb_queue
